mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sole owner of the single-ported RAM. Arbitrates between the instruction-cache read port and the data-cache read/write port.
- Sits between the cache pair serving the pipelined datapath and the RAM model.
- Data requests have priority. A starvation counter guarantees instruction fetch progress. A watchdog flags a RAM that never completes.

Parameters:
- STARVE_LIMIT, 3: consecutive completed data grants, with an instruction request pending, after which the instruction port wins the next arbitration.
- TIMEOUT, 255: maximum cycles a grant may wait for ramready before timeout_err sets.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- iREN  input  1  instruction read request, held until iwait low.
- iaddr  input  32  instruction word address.
- iload  output  32  instruction read data.
- iwait  output  1  instruction request pending/not yet complete.
- dREN  input  1  data read request, held until dwait low.
- dWEN  input  1  data write request, held until dwait low.
- daddr  input  32  data word address.
- dstore  input  32  data write value.
- dload  output  32  data read data.
- dwait  output  1  data request pending/not yet complete.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data, valid in the cycle ramready is high.
- ramready  input  1  RAM access complete, one cycle pulse.
- grant  output  2  00 idle, 01 instruction, 10 data (debug/hazard visibility).
- timeout_err  output  1  sticky watchdog error.

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous, active-low.
- Reset values: state IDLE, starve_cnt 0, wd_cnt 0, timeout_err 0.
  - All outputs are combinational from state, so under reset: ramREN/ramWEN 0, ramaddr/ramstore 0, grant 00.
  - iwait = iREN and dwait = dREN|dWEN.
- States:
  - IDLE:
    - If (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT), go to DGRANT.
    - Else if iREN, go to IGRANT.
    - Else stay.
    - This gives one cycle of arbitration latency. The RAM is never driven in IDLE.
  - DGRANT:
    - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. Write wins if both strobes are high.
    - On ramready, go to IDLE.
    - If iREN is high in that cycle, starve_cnt increments, saturating at STARVE_LIMIT; otherwise starve_cnt clears.
  - IGRANT:
    - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
    - On ramready, go to IDLE and clear starve_cnt.
- Completion:
  - dwait = (dREN|dWEN) & ~(state==DGRANT & ramready).
  - iwait = iREN & ~(state==IGRANT & ramready).
  - iload = dload = ramload (pass-through). Each requester samples only in its own completion cycle.
- Abort: if the granted requester drops all its request strobes while granted (no ramready), go to IDLE next cycle. RAM strobes drop immediately (combinational). starve_cnt is unchanged.
- Simultaneous ramready and request drop: treated as an abort, with no completion accounting.
- Back-to-back: every completion passes through IDLE, so the minimum cost is 2 cycles per access with a 0-wait RAM (ramready in the first granted cycle).
- Watchdog:
  - wd_cnt clears in IDLE and on ramready, and increments each granted cycle without ramready.
  - When wd_cnt reaches TIMEOUT, timeout_err sets and holds until reset. wd_cnt saturates.
  - Arbitration continues normally after the error.
- Reset mid-grant: returns to IDLE asynchronously. RAM strobes drop in the same instant.

Test Plan:
- Reset/idle: nRST low with iREN=1 → ramREN=0, grant=00, iwait=1. Release, then after 1 cycle grant=01, ramaddr=iaddr=0x0000_0040.
- Data priority: iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF, ramready after 2 cycles:
  - Required order: grant=10, ramWEN=1, ramstore=0xDEADBEEF, dwait drops in the ramready cycle.
  - Then IDLE, then grant=01.
- Starvation: iREN held high, dREN re-asserted continuously, STARVE_LIMIT=3 → exactly 3 data completions, then one instruction grant, then starve_cnt=0.
- Read return: dREN=1, daddr=0x200, ramload=0x12345678 with ramready → dload=0x12345678 and dwait=0 in the same cycle. iwait stays 1.
- Abort: grant data, then drop dREN before ramready → ramREN=0 that cycle, grant=00 next cycle, and a pending iREN is granted one cycle after.
- Watchdog: TIMEOUT=4, grant with ramready held low → timeout_err=1 after the 4th waiting cycle. It remains 1 after ramready arrives and clears only on nRST.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter: data-priority with instruction starvation guard and grant watchdog
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);

  // Encodings double as the grant debug output.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;
  logic            d_req;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (d_req && !(iREN && (starve_q == STARVE_MAX))) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        // A dropped request is an abort even if ramready coincides: no accounting.
        if (!d_req) begin
          state_d = IDLE;
        end else if (ramready) begin
          state_d = IDLE;
          if (iREN) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramready) begin
          state_d  = IDLE;
          starve_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == IDLE || ramready) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
    if (wd_d == WD_MAX) begin
      err_d = 1'b1;
    end
  end

  assign iload       = ramload;
  assign dload       = ramload;
  assign iwait       = iREN & ~((state_q == IGRANT) & ramready);
  assign dwait       = d_req & ~((state_q == DGRANT) & ramready);
  assign grant       = state_q;
  assign timeout_err = err_q;

endmodule
